// File: rtl/mux_arr_module.sv
// mux_arr_module: registered N-way bus multiplexer over a packed option array
module mux_arr_module #(
  parameter int WIDTH_IN  = 2,
  parameter int WIDTH_OP  = 4,
  parameter int WIDTH_BUS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [WIDTH_IN-1:0]                  in,
  input  logic [WIDTH_OP-1:0][WIDTH_BUS-1:0]   opt,
  output logic [WIDTH_BUS-1:0]                 out,
  output logic                                 out_valid,
  output logic                                 sel_err
);
  localparam int NSEL = 2 ** WIDTH_IN;
  localparam logic [WIDTH_IN:0] NOP = (WIDTH_IN + 1)'(WIDTH_OP);
  if (WIDTH_OP < 1 || WIDTH_OP > NSEL || WIDTH_BUS < 1) begin : g_param_err
    $error("mux_arr_module: need 1 <= WIDTH_OP <= 2**WIDTH_IN and WIDTH_BUS >= 1");
  end
  logic [NSEL-1:0][WIDTH_BUS-1:0] pad;
  logic                           err;
  assign err = {1'b0, in} >= NOP;
  // pad the option array to the full index range; unused slots read as zero
  always_comb begin
    pad = '0;
    pad[WIDTH_OP-1:0] = opt;
  end
  // register the selected entry; idle edges keep out and sel_err
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= pad[in];
        sel_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_mux_arr_module.sv
// tb_mux_arr_module: table-driven and randomized checks of mux_arr_module
module tb_mux_arr_module;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [1:0]      sel = '0;
  logic [3:0][1:0] opt_a;
  logic [2:0][1:0] opt_b;
  logic [1:0]      out_a, out_b;
  logic            vld_a, vld_b, err_a, err_b;
  int              n_chk = 0;
  int              n_fail = 0;
  int              mo[2], mv[2], me[2];

  assign opt_b = opt_a[2:0];

  always #5 clk = ~clk;

  mux_arr_module #(.WIDTH_IN(2), .WIDTH_OP(4), .WIDTH_BUS(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(sel), .opt(opt_a),
    .out(out_a), .out_valid(vld_a), .sel_err(err_a));

  mux_arr_module #(.WIDTH_IN(2), .WIDTH_OP(3), .WIDTH_BUS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(sel), .opt(opt_b),
    .out(out_b), .out_valid(vld_b), .sel_err(err_b));

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] sel;
    logic [7:0] opt;
    int         e_out;
    int         e_vld;
    int         e_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: entry k of a flat option word is bits [2k+1:2k]; any index at or
  // beyond the entry count yields zero and flags an error.
  task automatic model_edge();
    int flat;
    int nop;
    flat = int'(opt_a);
    for (int k = 0; k < 2; k++) begin
      nop = (k == 0) ? 4 : 3;
      if (rst) begin
        mo[k] = 0; mv[k] = 0; me[k] = 0;
      end else begin
        mv[k] = int'(in_valid);
        if (in_valid) begin
          me[k] = (int'(sel) >= nop) ? 1 : 0;
          mo[k] = me[k] ? 0 : (flat >> (2 * int'(sel))) % 4;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_b(input string tag);
    chk({tag, "_b_out"}, int'(out_b), mo[1]);
    chk({tag, "_b_vld"}, int'(vld_b), mv[1]);
    chk({tag, "_b_err"}, int'(err_b), me[1]);
  endtask

  task automatic chk_a_model(input string tag);
    chk({tag, "_a_out"}, int'(out_a), mo[0]);
    chk({tag, "_a_vld"}, int'(vld_a), mv[0]);
    chk({tag, "_a_err"}, int'(err_a), me[0]);
  endtask

  initial begin
    vec_t tbl[12];
    opt_a = 8'h6C;
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h6C, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'h6C, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 8'h6C, 0, 1, 0};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h6C, 3, 1, 0};
    tbl[4]  = '{1'b0, 1'b1, 2'd2, 8'h6C, 2, 1, 0};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 8'h6C, 1, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h6C, 1, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 2'd2, 8'h6C, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 8'h64, 1, 1, 0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 8'h6C, 2, 1, 0};
    tbl[10] = '{1'b1, 1'b1, 2'd1, 8'h6C, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 8'h6C, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; sel = tbl[i].sel; opt_a = tbl[i].opt;
      step();
      chk($sformatf("tbl%0d_out", i), int'(out_a), tbl[i].e_out);
      chk($sformatf("tbl%0d_vld", i), int'(vld_a), tbl[i].e_vld);
      chk($sformatf("tbl%0d_err", i), int'(err_a), tbl[i].e_err);
      chk_b($sformatf("tbl%0d", i));
    end

    // Out-of-range on the 3-entry instance, then back in range
    rst = 1'b0; in_valid = 1'b1; sel = 2'd3; opt_a = 8'h6C;
    step();
    chk("range_b_out", int'(out_b), 0);
    chk("range_b_err", int'(err_b), 1);
    chk("range_b_vld", int'(vld_b), 1);
    chk("range_a_out", int'(out_a), 1);
    chk("range_a_err", int'(err_a), 0);
    sel = 2'd2;
    step();
    chk("range2_b_out", int'(out_b), 2);
    chk("range2_b_err", int'(err_b), 0);

    // Inputs changing between edges must not disturb the registered output
    sel = 2'd1;
    step();
    chk("mid_pre_out", int'(out_a), 3);
    sel = 2'd3; opt_a = 8'hFF; in_valid = 1'b0;
    #3;
    chk("mid_hold_out", int'(out_a), 3);
    chk("mid_hold_vld", int'(vld_a), 1);
    step();
    chk("idle_out", int'(out_a), 3);
    chk("idle_vld", int'(vld_a), 0);

    // Randomized traffic against the reference model on both instances
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      in_valid = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      opt_a = 8'($urandom);
      step();
      chk_a_model($sformatf("rnd%0d", i));
      chk_b($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
